// File: rtl/tic_tac_toe_game.sv
// Two-player tic-tac-toe referee: 3x3 board registers, edge-detected move strobe, combinational result.
// Optional build macro TTT_ILLEGAL_FLAG_EN adds a one-cycle `illegal` pulse for rejected moves.
module tic_tac_toe_game (
   input  logic       clock,
   input  logic       reset,
   input  logic       play,
   input  logic [3:0] player1_position,
   input  logic [3:0] player2_position,
   output logic [1:0] pos1,
   output logic [1:0] pos2,
   output logic [1:0] pos3,
   output logic [1:0] pos4,
   output logic [1:0] pos5,
   output logic [1:0] pos6,
   output logic [1:0] pos7,
   output logic [1:0] pos8,
   output logic [1:0] pos9,
   output logic [1:0] who
`ifdef TTT_ILLEGAL_FLAG_EN
   ,
   output logic       illegal
`endif
);

   typedef enum logic {TURN_P1 = 1'b0, TURN_P2 = 1'b1} turn_t;

   turn_t             turn, turn_next;
   logic [8:0][1:0]   board, board_next;
   logic              play_q;
   logic              request;
   logic              legal;
   logic              cell_free;
   logic [3:0]        move_idx;
   logic              board_full;

   function automatic logic has_line(input logic [8:0][1:0] b, input logic [1:0] v);
      return (b[0] == v && b[1] == v && b[2] == v) ||
             (b[3] == v && b[4] == v && b[5] == v) ||
             (b[6] == v && b[7] == v && b[8] == v) ||
             (b[0] == v && b[3] == v && b[6] == v) ||
             (b[1] == v && b[4] == v && b[7] == v) ||
             (b[2] == v && b[5] == v && b[8] == v) ||
             (b[0] == v && b[4] == v && b[8] == v) ||
             (b[2] == v && b[4] == v && b[6] == v);
   endfunction

   // play is a level input from a debounced button: one move request per 0->1
   // transition, no handshake back to the source; rejected requests are dropped.
   always_ff @(posedge clock) begin
      if (reset) begin
         play_q <= 1'b0;
         turn   <= TURN_P1;
         board  <= '0;
      end else begin
         play_q <= play;
         turn   <= turn_next;
         board  <= board_next;
      end
   end

   always_comb begin
      board_next = board;
      turn_next  = turn;
      move_idx   = (turn == TURN_P1) ? player1_position : player2_position;
      request    = play & ~play_q;
      // Indices 9..15 never match, so an out-of-range move reads as "not free".
      cell_free  = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (move_idx == 4'(i)) cell_free = (board[i] == 2'b00);
      end
      legal = request && cell_free && (who == 2'b00);
      if (legal) begin
         for (int i = 0; i < 9; i++) begin
            if (move_idx == 4'(i)) board_next[i] = (turn == TURN_P1) ? 2'b01 : 2'b10;
         end
         turn_next = (turn == TURN_P1) ? TURN_P2 : TURN_P1;
      end
   end

   // Win is checked before draw so a ninth-move win is reported as a win.
   always_comb begin
      board_full = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (board[i] == 2'b00) board_full = 1'b0;
      end
      if (has_line(board, 2'b01))      who = 2'b01;
      else if (has_line(board, 2'b10)) who = 2'b10;
      else if (board_full)             who = 2'b11;
      else                             who = 2'b00;
   end

`ifdef TTT_ILLEGAL_FLAG_EN
   always_ff @(posedge clock) begin
      if (reset) illegal <= 1'b0;
      else       illegal <= request && !legal;
   end
`endif

   assign pos1 = board[0];
   assign pos2 = board[1];
   assign pos3 = board[2];
   assign pos4 = board[3];
   assign pos5 = board[4];
   assign pos6 = board[5];
   assign pos7 = board[6];
   assign pos8 = board[7];
   assign pos9 = board[8];

endmodule

// File: tb/tb_tic_tac_toe_game.sv
// Self-checking bench for tic_tac_toe_game: reference board model feeding an expected queue.
module tb_tic_tac_toe_game;

   logic       clock;
   logic       reset;
   logic       play;
   logic [3:0] player1_position;
   logic [3:0] player2_position;
   logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
   logic [1:0] who;
`ifdef TTT_ILLEGAL_FLAG_EN
   logic       illegal;
`endif

   tic_tac_toe_game dut (
      .clock            (clock),
      .reset            (reset),
      .play             (play),
      .player1_position (player1_position),
      .player2_position (player2_position),
      .pos1             (pos1),
      .pos2             (pos2),
      .pos3             (pos3),
      .pos4             (pos4),
      .pos5             (pos5),
      .pos6             (pos6),
      .pos7             (pos7),
      .pos8             (pos8),
      .pos9             (pos9),
      .who              (who)
`ifdef TTT_ILLEGAL_FLAG_EN
      ,
      .illegal          (illegal)
`endif
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [19:0] obs;
   assign obs = {who, pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

   // reference model
   logic [1:0]  m_board [9];
   logic        m_turn;
   int          win_lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
   logic [19:0] exp_q [$];
   int          checks;
   int          passes;

   function automatic logic [1:0] m_who();
      logic w1, w2, full;
      w1 = 1'b0; w2 = 1'b0; full = 1'b1;
      for (int l = 0; l < 8; l++) begin
         if (m_board[win_lines[l][0]] == 2'd1 && m_board[win_lines[l][1]] == 2'd1 &&
             m_board[win_lines[l][2]] == 2'd1) w1 = 1'b1;
         if (m_board[win_lines[l][0]] == 2'd2 && m_board[win_lines[l][1]] == 2'd2 &&
             m_board[win_lines[l][2]] == 2'd2) w2 = 1'b1;
      end
      for (int i = 0; i < 9; i++) if (m_board[i] == 2'd0) full = 1'b0;
      if (w1) return 2'b01;
      if (w2) return 2'b10;
      if (full) return 2'b11;
      return 2'b00;
   endfunction

   function automatic logic [19:0] model_vec();
      logic [19:0] v;
      v = '0;
      for (int i = 0; i < 9; i++) v[2*i +: 2] = m_board[i];
      v[19:18] = m_who();
      return v;
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 9; i++) m_board[i] = 2'b00;
      m_turn = 1'b0;
   endfunction

   function automatic void model_step(input logic [3:0] idx, output logic ill);
      ill = 1'b1;
      if (m_who() == 2'b00 && idx <= 4'd8) begin
         if (m_board[idx] == 2'b00) begin
            m_board[idx] = m_turn ? 2'b10 : 2'b01;
            m_turn       = ~m_turn;
            ill          = 1'b0;
         end
      end
   endfunction

   // driver tasks
   task automatic apply_reset(input int n);
      @(negedge clock);
      reset = 1'b1;
      play  = 1'b0;
      repeat (n) @(negedge clock);
      reset = 1'b0;
      model_clear();
   endtask

   task automatic do_move(input logic [3:0] p1, input logic [3:0] p2, input int hold, input int gap);
      logic [19:0] exp_v;
      logic        exp_ill;
      @(negedge clock);
      player1_position = p1;
      player2_position = p2;
      play             = 1'b1;
      model_step(m_turn ? p2 : p1, exp_ill);
      exp_q.push_back(model_vec());
      @(negedge clock);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL move_commit p1=%0d p2=%0d got=%h want=%h", p1, p2, obs, exp_v);
      else passes++;
`ifdef TTT_ILLEGAL_FLAG_EN
      checks++;
      if (illegal !== exp_ill) $display("FAIL illegal_pulse got=%b want=%b", illegal, exp_ill);
      else passes++;
`else
      exp_ill = 1'b0;
`endif
      // Positions wander while play stays high; no further move may be taken.
      for (int i = 1; i < hold; i++) begin
         player1_position = 4'($urandom_range(0, 15));
         player2_position = 4'($urandom_range(0, 15));
         @(negedge clock);
      end
`ifdef TTT_ILLEGAL_FLAG_EN
      if (hold > 1) begin
         checks++;
         if (illegal !== 1'b0) $display("FAIL illegal_width got=%b want=0", illegal);
         else passes++;
      end
`endif
      play = 1'b0;
      checks++;
      if (obs !== model_vec()) $display("FAIL hold_stable got=%h want=%h", obs, model_vec());
      else passes++;
      repeat (gap) @(negedge clock);
   endtask

   // Places idx through the current player's input; the other input gets noise.
   task automatic move_as(input logic [3:0] idx, input int hold, input int gap);
      logic [3:0] other;
      other = 4'($urandom_range(0, 15));
      if (m_turn) do_move(other, idx, hold, gap);
      else        do_move(idx, other, hold, gap);
   endtask

   // scenarios
   task automatic test_reset();
      apply_reset(10);
      @(negedge clock);
      checks++;
      if (obs !== 20'h0) $display("FAIL reset_state got=%h want=00000", obs);
      else passes++;
      // reset wins over a simultaneous play rise
      reset = 1'b1; play = 1'b1; player1_position = 4'd4; player2_position = 4'd4;
      @(negedge clock);
      checks++;
      if (obs !== 20'h0) $display("FAIL reset_priority got=%h want=00000", obs);
      else passes++;
      reset = 1'b0; play = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_win();
      apply_reset(2);
      do_move(4'd0, 4'd7, 5, 10);
      do_move(4'd6, 4'd1, 5, 10);
      do_move(4'd4, 4'd7, 5, 10);
      do_move(4'd3, 4'd2, 5, 10);
      do_move(4'd8, 4'd6, 5, 10);
      checks++;
      if (obs !== {2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b10, 2'b01})
         $display("FAIL win_board got=%h want=%h", obs,
                  {2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b10, 2'b01});
      else passes++;
      do_move(4'd3, 4'd3, 5, 10);
      checks++;
      if (pos4 !== 2'b00 || who !== 2'b01) $display("FAIL game_over_ignored pos4=%b who=%b want 00/01", pos4, who);
      else passes++;
   endtask

   task automatic test_hold();
      apply_reset(2);
      do_move(4'd0, 4'd4, 20, 5);
      checks++;
      if (obs !== {18'h0, 2'b01}) $display("FAIL hold_single got=%h want=%h", obs, {18'h0, 2'b01});
      else passes++;
      do_move(4'd0, 4'd4, 3, 5);
      checks++;
      if (pos5 !== 2'b10 || pos1 !== 2'b01) $display("FAIL turn_after_hold pos5=%b pos1=%b want 10/01", pos5, pos1);
      else passes++;
   endtask

   task automatic test_occupied();
      apply_reset(2);
      do_move(4'd0, 4'd3, 3, 4);
      do_move(4'd2, 4'd0, 3, 4);
      checks++;
      if (pos1 !== 2'b01 || pos3 !== 2'b00) $display("FAIL occupied_reject pos1=%b pos3=%b want 01/00", pos1, pos3);
      else passes++;
      do_move(4'd1, 4'd5, 3, 4);
      checks++;
      if (pos6 !== 2'b10 || pos2 !== 2'b00) $display("FAIL retry_same_player pos6=%b pos2=%b want 10/00", pos6, pos2);
      else passes++;
   endtask

   task automatic test_bad_index();
      apply_reset(2);
      do_move(4'd9, 4'd1, 3, 4);
      checks++;
      if (obs !== 20'h0) $display("FAIL bad_index got=%h want=00000", obs);
      else passes++;
      do_move(4'd15, 4'd1, 2, 3);
      do_move(4'd7, 4'd1, 2, 3);
      checks++;
      if (pos8 !== 2'b01 || pos2 !== 2'b00) $display("FAIL bad_index_turn pos8=%b pos2=%b want 01/00", pos8, pos2);
      else passes++;
   endtask

   task automatic test_draw();
      logic [3:0] seq [9] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};
      apply_reset(2);
      for (int i = 0; i < 9; i++) move_as(seq[i], 2, 2);
      checks++;
      if (who !== 2'b11) $display("FAIL draw got=%b want=11", who);
      else passes++;
      apply_reset(1);
      @(negedge clock);
      checks++;
      if (obs !== 20'h0) $display("FAIL reset_mid_game got=%h want=00000", obs);
      else passes++;
      do_move(4'd2, 4'd7, 2, 2);
      checks++;
      if (pos3 !== 2'b01 || pos8 !== 2'b00) $display("FAIL turn_after_reset pos3=%b pos8=%b want 01/00", pos3, pos8);
      else passes++;
   endtask

   task automatic test_random_games();
      for (int g = 0; g < 4; g++) begin
         apply_reset(2);
         for (int k = 0; k < 14 && m_who() == 2'b00; k++)
            move_as(4'($urandom_range(0, 10)), $urandom_range(1, 3), $urandom_range(1, 3));
         move_as(4'($urandom_range(0, 8)), 2, 2);
      end
   endtask

   initial begin
      checks = 0;
      passes = 0;
      reset  = 1'b1;
      play   = 1'b0;
      player1_position = 4'd0;
      player2_position = 4'd0;
      model_clear();
      test_reset();
      test_win();
      test_hold();
      test_occupied();
      test_bad_index();
      test_draw();
      test_random_games();
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL queue_drained got=%0d want=0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
